// File: rtl/program_fetch.sv
// Instruction fetch sequencer: sequences the registered program ROM and presents
// one/two-byte instructions over valid/ready. Optional macro: PROGRAM_FETCH_ILLEGAL_EN.
module program_fetch #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hF0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       branch_valid,
  input  logic [7:0] branch_target,
  output logic [7:0] opcode,
  output logic [7:0] operand,
  output logic [7:0] pc,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [2:0] {FETCH, LATCH_OP, LATCH_ARG, VALID, HALT} state_e;

  state_e     state_q, state_d;
  logic [7:0] rom_addr_q, rom_addr_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic       valid_q, valid_d;
  logic       halted_q, halted_d;
  logic [7:0] next_pc;

  function automatic logic has_operand(input logic [7:0] op);
    return (op[7:4] >= 4'h2) && (op[7:4] <= 4'hA);
  endfunction

`ifdef PROGRAM_FETCH_ILLEGAL_EN
  logic illegal_q, illegal_d;

  function automatic logic is_illegal(input logic [7:0] op);
    return (op[7:4] >= 4'hB) && (op[7:4] <= 4'hE);
  endfunction
`endif

  // Only meaningful in VALID; length comes from the already-latched opcode.
  assign next_pc = branch_valid ? branch_target
                                : pc_q + (has_operand(opcode_q) ? 8'd2 : 8'd1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:     state_d = LATCH_OP;
      LATCH_OP: begin
        if (rom_data == HALT_OPCODE)     state_d = HALT;
`ifdef PROGRAM_FETCH_ILLEGAL_EN
        else if (is_illegal(rom_data))   state_d = HALT;
`endif
        else if (has_operand(rom_data))  state_d = LATCH_ARG;
        else                             state_d = VALID;
      end
      LATCH_ARG: state_d = VALID;
      VALID:     if (instr_ready) state_d = FETCH;
      HALT:      state_d = HALT;
      default:   state_d = FETCH;
    endcase
  end

  always_comb begin
    rom_addr_d = rom_addr_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
`ifdef PROGRAM_FETCH_ILLEGAL_EN
    illegal_d  = illegal_q;
`endif
    unique case (state_q)
      FETCH:     rom_addr_d = pc_q + 8'd1;
      LATCH_OP: begin
        opcode_d  = rom_data;
        operand_d = '0;
`ifdef PROGRAM_FETCH_ILLEGAL_EN
        illegal_d = (rom_data != HALT_OPCODE) && is_illegal(rom_data);
`endif
      end
      LATCH_ARG: operand_d = rom_data;
      VALID: begin
        if (instr_ready) begin
          pc_d       = next_pc;
          rom_addr_d = next_pc;
        end
      end
      default: ;
    endcase
    // Flags are registered copies of the upcoming state so outputs come from flops.
    valid_d  = (state_d == VALID);
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q <= RESET_PC;
      pc_q       <= RESET_PC;
      opcode_q   <= '0;
      operand_q  <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
`ifdef PROGRAM_FETCH_ILLEGAL_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      rom_addr_q <= rom_addr_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
`ifdef PROGRAM_FETCH_ILLEGAL_EN
      illegal_q  <= illegal_d;
`endif
    end
  end

  assign rom_addr    = rom_addr_q;
  assign pc          = pc_q;
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
`ifdef PROGRAM_FETCH_ILLEGAL_EN
  assign illegal     = illegal_q;
`else
  assign illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_program_fetch.sv
// Bench for program_fetch: directed scenarios plus randomized program walk
// checked against an instruction-level reference model.
module tb_program_fetch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rom_addr, rom_data, branch_target, opcode, operand, pc;
  logic       instr_valid, instr_ready, branch_valid, halted, illegal;
  logic [7:0] rom_addr1, rom_data1, opcode1, operand1, pc1;
  logic       instr_valid1, instr_ready1, halted1, illegal1;

  logic [7:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data  <= mem[rom_addr];
    rom_data1 <= mem[rom_addr1];
  end

  program_fetch dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .opcode(opcode), .operand(operand), .pc(pc), .halted(halted), .illegal(illegal)
  );

  program_fetch #(.RESET_PC(8'hFF)) dut1 (
    .clk(clk), .rst(rst), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .instr_valid(instr_valid1), .instr_ready(instr_ready1),
    .branch_valid(1'b0), .branch_target(8'h00),
    .opcode(opcode1), .operand(operand1), .pc(pc1), .halted(halted1), .illegal(illegal1)
  );

  // Reference rules: operand present for opcodes 0x20..0xAF.
  function automatic bit m_two(input logic [7:0] op);
    return (op >= 8'h20) && (op < 8'hB0);
  endfunction

  function automatic bit m_illegal(input logic [7:0] op);
`ifdef PROGRAM_FETCH_ILLEGAL_EN
    return (op >= 8'hB0) && (op < 8'hF0);
`else
    return (op != op);
`endif
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Reset pulse; returns in the first FETCH cycle (negedge).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; instr_ready = 1'b0; branch_valid = 1'b0; instr_ready1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (instr_valid) begin lat = i; break; end
    end
  endtask

  task automatic wait_halted(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (halted) begin lat = i; break; end
    end
  endtask

  // Accept on the next edge; returns in the following FETCH cycle.
  task automatic accept(input logic br, input logic [7:0] tgt);
    instr_ready = 1'b1; branch_valid = br; branch_target = tgt;
    @(negedge clk);
    instr_ready = 1'b0; branch_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    mem[1] = 8'h10;
    @(negedge clk);
    rst = 1'b1; instr_ready = 1'b0; branch_valid = 1'b0; instr_ready1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({rom_addr, pc, opcode, operand, instr_valid, halted, illegal} !== {8'h00, 8'h00, 8'h00, 8'h00, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: got %h/%h/%h/%h/%b%b%b want 00/00/00/00/000",
               rom_addr, pc, opcode, operand, instr_valid, halted, illegal);
    end
    n_cmp++;
    if ({rom_addr1, pc1} !== 16'hFFFF) begin
      n_err++;
      $display("FAIL reset_pc_param: got rom_addr %h pc %h want ff ff", rom_addr1, pc1);
    end
    rst = 1'b0;
  endtask

  task automatic test_one_byte();
    int lat;
    wait_valid(lat);
    n_cmp++;
    if ({lat, opcode, operand, pc} !== {32'sd2, 8'h00, 8'h00, 8'h00}) begin
      n_err++;
      $display("FAIL one_byte_first: got lat %0d op %h arg %h pc %h want 2 00 00 00", lat, opcode, operand, pc);
    end
    accept(1'b0, 8'h00);
    wait_valid(lat);
    n_cmp++;
    if ({lat + 1, opcode, pc} !== {32'sd3, 8'h10, 8'h01}) begin
      n_err++;
      $display("FAIL one_byte_next: got lat %0d op %h pc %h want 3 10 01", lat + 1, opcode, pc);
    end
  endtask

  task automatic test_two_byte();
    int lat;
    clear_mem();
    mem[0] = 8'h20; mem[1] = 8'h05;
    do_reset();
    wait_valid(lat);
    n_cmp++;
    if ({lat, opcode, operand, pc} !== {32'sd3, 8'h20, 8'h05, 8'h00}) begin
      n_err++;
      $display("FAIL two_byte_first: got lat %0d op %h arg %h pc %h want 3 20 05 00", lat, opcode, operand, pc);
    end
    accept(1'b0, 8'h00);
    wait_valid(lat);
    n_cmp++;
    if ({lat + 1, opcode, operand, pc} !== {32'sd3, 8'h00, 8'h00, 8'h02}) begin
      n_err++;
      $display("FAIL two_byte_next: got lat %0d op %h arg %h pc %h want 3 00 00 02", lat + 1, opcode, operand, pc);
    end
  endtask

  task automatic test_hold_branch();
    int lat;
    clear_mem();
    mem[4] = 8'h30; mem[5] = 8'hAA; mem[8'h40] = 8'h10;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_valid(lat);
      accept(1'b0, 8'h00);
    end
    wait_valid(lat);
    n_cmp++;
    if ({lat + 1, opcode, operand, pc} !== {32'sd4, 8'h30, 8'hAA, 8'h04}) begin
      n_err++;
      $display("FAIL hold_present: got lat %0d op %h arg %h pc %h want 4 30 aa 04", lat + 1, opcode, operand, pc);
    end
    for (int i = 0; i < 10; i++) begin
      branch_valid = 1'($urandom);
      branch_target = 8'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({instr_valid, opcode, operand, pc} !== {1'b1, 8'h30, 8'hAA, 8'h04}) begin
        n_err++;
        $display("FAIL hold_stable: cycle %0d got %b %h %h %h want 1 30 aa 04", i, instr_valid, opcode, operand, pc);
      end
    end
    accept(1'b1, 8'h40);
    n_cmp++;
    if (rom_addr !== 8'h40) begin
      n_err++;
      $display("FAIL branch_rom_addr: got %h want 40", rom_addr);
    end
    wait_valid(lat);
    n_cmp++;
    if ({opcode, pc} !== {8'h10, 8'h40}) begin
      n_err++;
      $display("FAIL branch_target: got op %h pc %h want 10 40", opcode, pc);
    end
  endtask

  task automatic test_wrap_reset_pc();
    int lat;
    clear_mem();
    mem[8'hFF] = 8'h80; mem[0] = 8'h07;
    do_reset();
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (instr_valid1) begin lat = i; break; end
    end
    n_cmp++;
    if ({lat, opcode1, operand1, pc1} !== {32'sd3, 8'h80, 8'h07, 8'hFF}) begin
      n_err++;
      $display("FAIL wrap_present: got lat %0d op %h arg %h pc %h want 3 80 07 ff", lat, opcode1, operand1, pc1);
    end
    instr_ready1 = 1'b1;
    @(negedge clk);
    instr_ready1 = 1'b0;
    n_cmp++;
    if ({pc1, rom_addr1} !== 16'h0101) begin
      n_err++;
      $display("FAIL wrap_next_pc: got pc %h rom_addr %h want 01 01", pc1, rom_addr1);
    end
  endtask

  task automatic test_halt();
    int lat;
    logic ok;
    clear_mem();
    mem[3] = 8'hF0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wait_valid(lat);
      accept(1'b0, 8'h00);
    end
    instr_ready = 1'b1;
    wait_halted(lat);
    n_cmp++;
    if ({lat, instr_valid, illegal, opcode} !== {32'sd2, 1'b0, 1'b0, 8'hF0}) begin
      n_err++;
      $display("FAIL halt_detect: got lat %0d valid %b illegal %b op %h want 2 0 0 f0", lat, instr_valid, illegal, opcode);
    end
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      branch_valid = 1'($urandom);
      @(negedge clk);
      if (instr_valid !== 1'b0 || halted !== 1'b1 || rom_addr !== 8'h04 || pc !== 8'h03) ok = 1'b0;
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL halt_hold: got valid %b halted %b rom_addr %h pc %h want 0 1 04 03", instr_valid, halted, rom_addr, pc);
    end
    do_reset();
    wait_valid(lat);
    n_cmp++;
    if ({lat, pc, halted} !== {32'sd2, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL halt_restart: got lat %0d pc %h halted %b want 2 00 0", lat, pc, halted);
    end
  endtask

  task automatic test_illegal();
    int lat;
    clear_mem();
    mem[0] = 8'hB0;
    do_reset();
`ifdef PROGRAM_FETCH_ILLEGAL_EN
    wait_halted(lat);
    n_cmp++;
    if ({lat, illegal, instr_valid} !== {32'sd2, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL illegal_halt: got lat %0d illegal %b valid %b want 2 1 0", lat, illegal, instr_valid);
    end
`else
    wait_valid(lat);
    n_cmp++;
    if ({lat, opcode, operand, illegal, halted} !== {32'sd2, 8'hB0, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL illegal_off: got lat %0d op %h arg %h ill %b halt %b want 2 b0 00 0 0",
               lat, opcode, operand, illegal, halted);
    end
`endif
  endtask

  task automatic test_random();
    int lat, want_lat;
    logic [7:0] b, mpc, a1, eop, earg, tgt;
    logic br;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      if (b >= 8'hF0 || m_illegal(b)) b = b - 8'h80;
      mem[i] = b;
    end
    mpc = 8'h00;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      eop = mem[mpc];
      a1 = mpc + 8'd1;
      earg = m_two(eop) ? mem[a1] : 8'h00;
      want_lat = m_two(eop) ? 3 : 2;
      wait_valid(lat);
      n_cmp++;
      if ({lat, opcode, operand, pc} !== {want_lat, eop, earg, mpc}) begin
        n_err++;
        $display("FAIL rand_instr[%0d]: got lat %0d op %h arg %h pc %h want %0d %h %h %h",
                 n, lat, opcode, operand, pc, want_lat, eop, earg, mpc);
      end
      repeat ($urandom_range(0, 3)) begin
        branch_valid = 1'($urandom);
        @(negedge clk);
      end
      br = ($urandom_range(0, 3) == 0);
      tgt = 8'($urandom);
      accept(br, tgt);
      mpc = br ? tgt : mpc + (m_two(eop) ? 8'd2 : 8'd1);
      n_cmp++;
      if ({rom_addr, pc, instr_valid} !== {mpc, mpc, 1'b0}) begin
        n_err++;
        $display("FAIL rand_next[%0d]: got rom_addr %h pc %h valid %b want %h %h 0",
                 n, rom_addr, pc, instr_valid, mpc, mpc);
      end
    end
  endtask

  initial begin
    instr_ready = 1'b0; branch_valid = 1'b0; branch_target = 8'h00; instr_ready1 = 1'b0;
    test_reset();
    test_one_byte();
    test_two_byte();
    test_hold_branch();
    test_wrap_reset_pc();
    test_halt();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
